inst_fetch_mem: RTL and testbench
=================================

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8, SHALL set the fetch and load address width in bits.
REQ-003 Parameter DEPTH, default 256, SHALL set the number of implemented words; valid range is 1..2**ADDR_W.
REQ-004 Parameter NOP_WORD, default 8'b01111000 (resized to DATA_W), SHALL set the fill value for every word and the out-of-range read value.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-006 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-007 load_en  input  1  SHALL request a program-load write this cycle.
REQ-008 load_addr  input  ADDR_W  SHALL give the write address.
REQ-009 load_data  input  DATA_W  SHALL give the write data.
REQ-010 req_valid  input  1  SHALL indicate that a fetch request is present.
REQ-011 req_ready  output  1  SHALL indicate that the block accepts the fetch request this cycle.
REQ-012 req_addr  input  ADDR_W  SHALL give the fetch address.
REQ-013 rsp_valid  output  1  SHALL indicate that a fetched word is present.
REQ-014 rsp_ready  input  1  SHALL indicate that the consumer takes the response this cycle.
REQ-015 rsp_data  output  DATA_W  SHALL carry the fetched instruction word.
REQ-016 rsp_addr  output  ADDR_W  SHALL echo the address of the fetch that produced rsp_data.
REQ-017 rsp_err  output  1  SHALL flag a fetch whose address is >= DEPTH.

Function
REQ-018 At time zero, all DEPTH words SHALL hold NOP_WORD.
REQ-019 A fetch SHALL be accepted on a clock edge where req_valid and req_ready are both 1.
REQ-020 req_ready SHALL equal (!rsp_valid || rsp_ready) && !load_en && !reset; it is combinational.
REQ-021 Latency SHALL be one cycle: an accepted fetch at edge N drives rsp_valid=1 with its data, address and error flag after edge N.
REQ-022 Response registers SHALL hold stable while rsp_valid=1 and rsp_ready=0 (no drop, no overwrite).
REQ-023 If rsp_valid=1, rsp_ready=1 and a new fetch is accepted in the same cycle, the next response SHALL replace the current one back-to-back (one word per cycle throughput).
REQ-024 If rsp_ready=1 and no fetch is accepted, rsp_valid SHALL go to 0 on the next edge.
REQ-025 A load with load_addr < DEPTH SHALL write memory on the edge; a load with load_addr >= DEPTH SHALL be ignored silently.
REQ-026 Load SHALL take priority over fetch; in a load cycle req_ready=0, so a load and a fetch are never accepted on the same edge.
REQ-027 A fetch accepted on the cycle after a load to the same address SHALL return the newly written data.
REQ-028 A fetch with req_addr >= DEPTH SHALL return rsp_data=NOP_WORD and rsp_err=1; in-range fetches SHALL return rsp_err=0.
REQ-029 Address arithmetic SHALL be unsigned ADDR_W-bit; there is no wrap-around and no address increment inside the block.

Reset
REQ-030 While reset=1 on an edge: rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0 after the edge.
REQ-031 Reset SHALL NOT alter memory contents; previously loaded words survive reset.
REQ-032 A response pending when reset asserts SHALL be discarded; a load coincident with reset SHALL still be performed.

Configuration
REQ-033 Macro INST_FETCH_MEM_STATS_EN, when defined, SHALL add output fetch_count (16 bits), reset to 0, which increments once per accepted fetch (in-range or not) and saturates at 16'hFFFF.
REQ-034 Without INST_FETCH_MEM_STATS_EN, port fetch_count and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Reset, then fetch addr 0x05 with rsp_ready=1 -> one cycle later rsp_valid=1, rsp_data=8'b01111000, rsp_addr=0x05, rsp_err=0.
REQ-036 Load 0x10<=8'hA5, then fetch 0x10 on the next cycle -> rsp_data=8'hA5; assert reset, fetch 0x10 again -> still 8'hA5.
REQ-037 With DEPTH=200, fetch 0xC8 -> rsp_data=NOP_WORD, rsp_err=1; load to 0xC8 -> a later fetch of 0xC7 is unaffected.
REQ-038 Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response stable for 3 cycles; then rsp_ready=1 with 4 consecutive fetches of 0x00..0x03 -> 4 responses on consecutive cycles.
REQ-039 Assert load_en and req_valid together -> req_ready=0 that cycle; the fetch is accepted the following cycle.
REQ-040 With INST_FETCH_MEM_STATS_EN defined, issue 5 accepted fetches -> fetch_count=5; reset -> fetch_count=0.

Source files
------------

// File: rtl/inst_fetch_mem.sv
// Instruction memory with valid/ready fetch port and program-load port; optional fetch counter under INST_FETCH_MEM_STATS_EN.
// One-cycle fetch latency; the response register stalls under rsp_ready=0 and req_ready drops until it drains.
module inst_fetch_mem #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(8'b01111000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err
`ifdef INST_FETCH_MEM_STATS_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // Power-up contents are NOP; reset deliberately leaves the array alone.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

    logic              load_in_range;
    logic              req_in_range;
    logic              fetch_acc;
    logic [IDX_W-1:0]  load_idx;
    logic [IDX_W-1:0]  req_idx;

    assign load_in_range = ({1'b0, load_addr} < DEPTH_C);
    assign req_in_range  = ({1'b0, req_addr} < DEPTH_C);
    assign load_idx      = load_addr[IDX_W-1:0];
    assign req_idx       = req_addr[IDX_W-1:0];

    assign req_ready = (!rsp_valid || rsp_ready) && !load_en && !reset;
    assign fetch_acc = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
        end else if (fetch_acc) begin
            rsp_valid <= 1'b1;
            rsp_data  <= req_in_range ? mem[req_idx] : NOP_WORD;
            rsp_addr  <= req_addr;
            rsp_err   <= !req_in_range;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef INST_FETCH_MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (fetch_acc && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Bench for inst_fetch_mem (DEPTH=200): directed scenarios then random traffic against a reference model.
module tb_inst_fetch_mem;

    localparam int DEPTH = 200;
    localparam logic [7:0] NOP = 8'b01111000;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] rsp_addr;
    logic       rsp_err;
`ifdef INST_FETCH_MEM_STATS_EN
    logic [15:0] fetch_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state: memory image plus the single outstanding response slot.
    logic [7:0] mm [256];
    logic       m_vld;
    logic [7:0] m_data;
    logic [7:0] m_addr;
    logic       m_err;
    logic       m_known;
    int         m_cnt;

    always #5 clk = ~clk;

    inst_fetch_mem #(
        .DATA_W  (8),
        .ADDR_W  (8),
        .DEPTH   (DEPTH),
        .NOP_WORD(NOP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_addr (rsp_addr),
        .rsp_err  (rsp_err)
`ifdef INST_FETCH_MEM_STATS_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic step(input string tag);
        logic exp_rdy;
        logic acc;
        exp_rdy = (!m_vld || rsp_ready) && !load_en && !reset;
        acc = req_valid && exp_rdy;
        #1;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (reset) begin
            m_vld = 1'b0; m_data = '0; m_addr = '0; m_err = 1'b0; m_known = 1'b1; m_cnt = 0;
        end else if (acc) begin
            m_vld   = 1'b1;
            m_data  = (int'(req_addr) < DEPTH) ? mm[req_addr] : NOP;
            m_addr  = req_addr;
            m_err   = (int'(req_addr) >= DEPTH);
            m_known = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end else if (rsp_ready) begin
            m_vld = 1'b0;
        end
        if (load_en && int'(load_addr) < DEPTH) mm[load_addr] = load_data;
        #1;
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_vld));
        if (m_vld || (m_known && reset)) begin
            check({tag, ".rsp_data"}, 32'(rsp_data), 32'(m_data));
            check({tag, ".rsp_addr"}, 32'(rsp_addr), 32'(m_addr));
            check({tag, ".rsp_err"},  32'(rsp_err),  32'(m_err));
        end
`ifdef INST_FETCH_MEM_STATS_EN
        check({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_cnt));
`endif
        @(negedge clk);
    endtask

    task automatic fetch(input logic [7:0] a);
        idle(); req_valid = 1'b1; req_addr = a;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        idle(); load_en = 1'b1; load_addr = a; load_data = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mm[i] = NOP;
        m_vld = 1'b0; m_data = '0; m_addr = '0; m_err = 1'b0; m_known = 1'b0; m_cnt = 0;
        idle();
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        reset = 1'b1; step("rst0");
        reset = 1'b1; step("rst1");
        check("rst.rsp_data_zero", 32'(rsp_data), 32'h0);
        check("rst.rsp_addr_zero", 32'(rsp_addr), 32'h0);

        // Fetch of an unloaded word returns NOP
        fetch(8'h05); step("f05");
        check("f05.data_const", 32'(rsp_data), 32'h78);
        check("f05.addr_const", 32'(rsp_addr), 32'h05);
        idle(); step("f05.drain");

        // Load then fetch, survives reset
        load(8'h10, 8'hA5); step("ld10");
        fetch(8'h10); step("f10");
        check("f10.data_const", 32'(rsp_data), 32'hA5);
        idle(); reset = 1'b1; step("rst2");
        fetch(8'h10); step("f10.after_rst");
        check("f10r.data_const", 32'(rsp_data), 32'hA5);

        // Out-of-range fetch and load
        fetch(8'hC8); step("fC8");
        check("fC8.err_const", 32'(rsp_err), 32'h1);
        check("fC8.data_const", 32'(rsp_data), 32'(NOP));
        load(8'hC8, 8'h33); step("ldC8");
        fetch(8'hC7); step("fC7");
        check("fC7.data_const", 32'(rsp_data), 32'(NOP));
        fetch(8'hFF); step("fFF");
        check("fFF.err_const", 32'(rsp_err), 32'h1);

        // Backpressure hold then back-to-back stream
        load(8'h01, 8'h11); step("ld01");
        load(8'h02, 8'h22); step("ld02");
        fetch(8'h01); rsp_ready = 1'b0; step("bp.acc");
        for (int i = 0; i < 3; i++) begin
            fetch(8'h02); rsp_ready = 1'b0; step("bp.hold");
            check("bp.hold_data", 32'(rsp_data), 32'h11);
        end
        for (int i = 0; i < 4; i++) begin
            fetch(8'(i)); step("b2b");
            check("b2b.addr_const", 32'(rsp_addr), 32'(i));
            check("b2b.valid_const", 32'(rsp_valid), 32'h1);
        end
        idle(); step("b2b.drain");

        // Load has priority over a concurrent fetch
        load(8'h30, 8'h3C); req_valid = 1'b1; req_addr = 8'h30; step("ldpri");
        check("ldpri.no_rsp", 32'(rsp_valid), 32'h0);
        fetch(8'h30); step("ldpri.fetch");
        check("ldpri.data_const", 32'(rsp_data), 32'h3C);

        // Pending response dropped by reset; coincident load still lands
        fetch(8'h30); rsp_ready = 1'b0; step("pend");
        load(8'h20, 8'h5A); reset = 1'b1; step("rst.load");
        fetch(8'h20); step("f20");
        check("f20.data_const", 32'(rsp_data), 32'h5A);

`ifdef INST_FETCH_MEM_STATS_EN
        idle(); reset = 1'b1; step("cnt.rst");
        for (int i = 0; i < 5; i++) begin
            fetch(8'(i * 50)); step("cnt.f");
        end
        idle(); step("cnt.idle");
        check("cnt.five", 32'(fetch_count), 32'd5);
        idle(); reset = 1'b1; step("cnt.rst2");
        check("cnt.zero", 32'(fetch_count), 32'd0);
`endif

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            reset     = ($urandom_range(0, 59) == 0);
            load_en   = ($urandom_range(0, 4) == 0);
            load_addr = 8'($urandom_range(0, 255));
            load_data = 8'($urandom);
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15))
                                                    : 8'($urandom_range(0, 255));
            rsp_ready = ($urandom_range(0, 2) != 0);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
